// File: rtl/rll_key_pkg.sv
// Shared definitions for the RLL16 key loader.
//   key_state_e    : loader FSM states
//   KEY_W_DEFAULT  : default key width (keyIn bus width of the locked netlist)
//   KEY_W_MAX      : widest key the parity helper accepts
//   key_parity()   : XOR reduction of a key vector, zero-extended to KEY_W_MAX
package rll_key_pkg;

    localparam int KEY_W_DEFAULT = 16;
    localparam int KEY_W_MAX     = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CHECK = 3'd2,
        APPLY = 3'd3,
        ERROR = 3'd4
    } key_state_e;

    // Zero-extension does not change the XOR, so narrower keys pad with zeros.
    function automatic logic key_parity(input logic [KEY_W_MAX-1:0] vec);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < KEY_W_MAX; i++) begin
            acc = acc ^ vec[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/rll_key_shifter.sv
// Serial-to-parallel key shifter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart the frame (shadow, bit count and parity cleared)
//   shift_en    : a qualified serial bit is present this cycle
//   sdi         : serial data, LSB first, parity bit after the last key bit
//   shadow      : assembled key bits
//   parity      : captured parity bit
//   frame_done  : the current shift_en carries the parity bit
module rll_key_shifter
    import rll_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [KEY_W-1:0] shadow,
    output logic             parity,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] shadow_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             parity_r;

    assign shadow     = shadow_r;
    assign parity     = parity_r;
    // Once all key bits are in, the next qualified bit is the parity bit.
    assign frame_done = shift_en && (bit_cnt_r == CNT_W'(KEY_W));

    // Shadow register, bit counter and parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r  <= {KEY_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            parity_r  <= 1'b0;
        end else if (clear) begin
            shadow_r  <= {KEY_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            parity_r  <= 1'b0;
        end else if (shift_en) begin
            if (bit_cnt_r < CNT_W'(KEY_W)) begin
                // Decoded write keeps the index width independent of KEY_W.
                for (int i = 0; i < KEY_W; i++) begin
                    if (bit_cnt_r == CNT_W'(i)) begin
                        shadow_r[i] <= sdi;
                    end
                end
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
                parity_r <= sdi;
            end
        end
    end

endmodule

// File: rtl/rll_key_loader.sv
// Loads, parity-checks and holds the unlock key of an RLL16 locked netlist.
// Ports:
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset
//   key_start      : one-cycle pulse beginning (or restarting) a key frame
//   key_sdi        : serial key data, LSB first, then an even-parity bit
//   key_sdi_valid  : qualifies key_sdi
//   key_lock       : freezes the applied key until the next reset
//   key_out        : key bus; bit i drives keyIn_0_i of the locked netlist
//   key_applied    : key_out has been stable for SETTLE_CYCLES; sample now
//   busy           : frame in progress, being checked, or settling
//   err            : sticky frame error (bad parity or timeout)
//   locked         : lock is in effect
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_W         = KEY_W_DEFAULT,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_sdi,
    input  logic             key_sdi_valid,
    input  logic             key_lock,
    output logic [KEY_W-1:0] key_out,
    output logic             key_applied,
    output logic             busy,
    output logic             err,
    output logic             locked
);

    localparam int SET_W  = 4;
    localparam int IDLE_W = 8;

    key_state_e       state_r;
    key_state_e       state_nxt_s;
    logic             restart_s;
    logic             shift_en_s;
    logic             frame_done_s;
    logic             parity_s;
    logic             parity_ok_s;
    logic [KEY_W-1:0] shadow_s;

    logic [IDLE_W-1:0] idle_cnt_r;
    logic [SET_W-1:0]  settle_cnt_r;
    logic [KEY_W-1:0]  key_out_r;
    logic              key_applied_r;
    logic              busy_r;
    logic              err_r;
    logic              locked_r;

    assign key_out     = key_out_r;
    assign key_applied = key_applied_r;
    assign busy        = busy_r;
    assign err         = err_r;
    assign locked      = locked_r;

    // A start pulse always wins over a data bit in the same cycle.
    assign shift_en_s  = (state_r == SHIFT) && key_sdi_valid && !key_start;
    assign parity_ok_s = (key_parity(KEY_W_MAX'(shadow_s)) == parity_s);

    rll_key_shifter #(
        .KEY_W (KEY_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (restart_s),
        .shift_en   (shift_en_s),
        .sdi        (key_sdi),
        .shadow     (shadow_s),
        .parity     (parity_s),
        .frame_done (frame_done_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and frame restart decode.
    always_comb begin
        state_nxt_s = state_r;
        restart_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_start && !locked_r) begin
                    state_nxt_s = SHIFT;
                    restart_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (key_start) begin
                    state_nxt_s = SHIFT;
                    restart_s   = 1'b1;
                end else if (frame_done_s) begin
                    state_nxt_s = CHECK;
                end else if (!key_sdi_valid && (idle_cnt_r == IDLE_W'(TIMEOUT - 1))) begin
                    state_nxt_s = ERROR;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            CHECK: begin
                if (parity_ok_s) begin
                    state_nxt_s = APPLY;
                end else begin
                    state_nxt_s = ERROR;
                end
            end
            APPLY: begin
                // settle_cnt is 0 on the first APPLY cycle (load cycle) and
                // reaches 1 on the last one.
                if (settle_cnt_r == 4'd1) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = APPLY;
                end
            end
            ERROR: begin
                if (key_start && !locked_r) begin
                    state_nxt_s = SHIFT;
                    restart_s   = 1'b1;
                end else begin
                    state_nxt_s = ERROR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                restart_s   = 1'b0;
            end
        endcase
    end

    // Inactivity timer inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= 8'd0;
        end else if (restart_s) begin
            idle_cnt_r <= 8'd0;
        end else if (state_r == SHIFT) begin
            if (key_sdi_valid) begin
                idle_cnt_r <= 8'd0;
            end else begin
                idle_cnt_r <= idle_cnt_r + 8'd1;
            end
        end
    end

    // Key bus update and settle countdown; the held key only changes in APPLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_out_r     <= {KEY_W{1'b0}};
            key_applied_r <= 1'b0;
            settle_cnt_r  <= 4'd0;
        end else if (state_r == APPLY) begin
            if (settle_cnt_r == 4'd0) begin
                key_out_r     <= shadow_s;
                key_applied_r <= 1'b0;
                settle_cnt_r  <= SET_W'(SETTLE_CYCLES);
            end else if (settle_cnt_r == 4'd1) begin
                key_applied_r <= 1'b1;
                settle_cnt_r  <= 4'd0;
            end else begin
                settle_cnt_r  <= settle_cnt_r - 4'd1;
            end
        end
    end

    // Registered busy / err status, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == SHIFT) || (state_nxt_s == CHECK) ||
                      (state_nxt_s == APPLY);
            err_r  <= (state_nxt_s == ERROR);
        end
    end

    // One-way lock, only from a settled key in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_r <= 1'b0;
        end else if ((state_r == IDLE) && key_lock && key_applied_r) begin
            locked_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: directed scenarios plus randomized
// frames against a frame-level reference model (held key, applied, err, lock).
module tb_rll_key_loader;

    localparam int KW     = 16;
    localparam int SETTLE = 2;
    localparam int TMO    = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_start;
    logic          key_sdi;
    logic          key_sdi_valid;
    logic          key_lock;
    logic [KW-1:0] key_out;
    logic          key_applied;
    logic          busy;
    logic          err;
    logic          locked;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [KW-1:0] m_key;
    logic          m_applied;
    logic          m_err;
    logic          m_locked;

    rll_key_loader #(
        .KEY_W         (KW),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT       (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_start     (key_start),
        .key_sdi       (key_sdi),
        .key_sdi_valid (key_sdi_valid),
        .key_lock      (key_lock),
        .key_out       (key_out),
        .key_applied   (key_applied),
        .busy          (busy),
        .err           (err),
        .locked        (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_key     = '0;
        m_applied = 1'b0;
        m_err     = 1'b0;
        m_locked  = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_key"},     key_out,     m_key);
        check_eq({tag, "_applied"}, key_applied, m_applied);
        check_eq({tag, "_err"},     err,         m_err);
        check_eq({tag, "_locked"},  locked,      m_locked);
    endtask

    // Start pulse, sometimes with a (to-be-ignored) data bit alongside.
    task automatic start_pulse();
        key_start     = 1'b1;
        key_sdi_valid = 1'($urandom_range(0, 1));
        key_sdi       = 1'($urandom_range(0, 1));
        tick();
        key_start     = 1'b0;
        key_sdi_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [KW-1:0] key, input int nbits, input int gap_max);
        for (int i = 0; i < nbits; i++) begin
            int g;
            g = int'($urandom_range(0, gap_max));
            key_sdi_valid = 1'b0;
            for (int j = 0; j < g; j++) tick();
            key_sdi_valid = 1'b1;
            key_sdi       = key[i];
            tick();
        end
        key_sdi_valid = 1'b0;
    endtask

    task automatic send_parity(input logic p);
        key_sdi_valid = 1'b1;
        key_sdi       = p;
        tick();
        key_sdi_valid = 1'b0;
    endtask

    // Full frame from start pulse through settle (or error), checked vs model.
    task automatic run_frame(input logic [KW-1:0] key, input logic par, input int gap_max);
        bit good;
        start_pulse();
        check_eq("start_err",  err,  1'b0);
        check_eq("start_busy", busy, 1'b1);
        m_err = 1'b0;
        send_bits(key, KW, gap_max);
        check_eq("shift_busy", busy, 1'b1);
        send_parity(par);
        good = ((($countones(key) + int'(par)) % 2) == 0);
        tick(); // T+1: CHECK decided
        if (good) begin
            check_eq("t1_hold_key", key_out,     m_key);
            check_eq("t1_applied",  key_applied, m_applied);
            check_eq("t1_busy",     busy,        1'b1);
            tick(); // T+2: key bus updated
            check_eq("t2_key",     key_out,     key);
            check_eq("t2_applied", key_applied, 1'b0);
            m_key     = key;
            m_applied = 1'b0;
            for (int s = 1; s < SETTLE; s++) begin
                tick();
                check_eq("settle_applied", key_applied, 1'b0);
            end
            tick(); // T+2+SETTLE
            m_applied = 1'b1;
            check_model("done");
            check_eq("done_busy", busy, 1'b0);
        end else begin
            m_err = 1'b1;
            check_model("bad");
            check_eq("bad_busy", busy, 1'b0);
        end
    endtask

    initial begin
        logic [KW-1:0] k;
        logic          p;
        rst_n         = 1'b0;
        key_start     = 1'b0;
        key_sdi       = 1'b0;
        key_sdi_valid = 1'b0;
        key_lock      = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        check_eq("reset_busy", busy, 1'b0);
        #3 rst_n = 1'b1;
        tick();

        // Lock without an applied key is ignored
        key_lock = 1'b1;
        tick();
        key_lock = 1'b0;
        check_eq("lock_noapplied", locked, 1'b0);

        // Good frame 0xA5C3
        run_frame(16'hA5C3, 1'b0, 0);

        // Bad parity frame while 0xA5C3 held
        run_frame(16'h0001, 1'b0, 0);
        key_lock = 1'b1;
        tick();
        key_lock = 1'b0;
        check_eq("lock_in_error", locked, 1'b0);
        check_eq("err_sticky",    err,    1'b1);

        // Timeout after 8 bits
        start_pulse();
        m_err = 1'b0;
        send_bits(16'h00FF, 8, 0);
        for (int i = 0; i < TMO - 1; i++) tick();
        check_eq("tmo_before_err",  err,  1'b0);
        check_eq("tmo_before_busy", busy, 1'b1);
        tick();
        m_err = 1'b1;
        check_model("tmo");
        check_eq("tmo_busy", busy, 1'b0);

        // Restart after 10 bits, then 0x1234 with parity 1
        start_pulse();
        send_bits(16'hFFFF, 10, 0);
        run_frame(16'h1234, 1'b1, 0);

        // Randomized frames: random keys, gaps, restarts, parity errors
        for (int n = 0; n < 24; n++) begin
            k = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                start_pulse();
                send_bits(16'($urandom), int'($urandom_range(0, KW)), 1);
            end
            p = 1'($countones(k) % 2);
            if ($urandom_range(0, 3) == 0) p = ~p;
            run_frame(k, p, int'($urandom_range(0, 3)));
        end

        // Lock after 0xA5C3, later frame ignored, reset clears
        run_frame(16'hA5C3, 1'b0, 0);
        key_lock = 1'b1;
        tick();
        key_lock = 1'b0;
        m_locked = 1'b1;
        check_eq("lock_set", locked, 1'b1);
        start_pulse();
        check_eq("locked_start_busy", busy, 1'b0);
        send_bits(16'hFFFF, KW, 0);
        send_parity(1'b0);
        repeat (SETTLE + 2) tick();
        check_model("locked_frame");
        check_eq("locked_busy", busy, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("lock_reset");
        #5 rst_n = 1'b1;
        tick();

        // Async reset mid-APPLY with settle_cnt == 1
        run_frame(16'hA5C3, 1'b0, 0);
        start_pulse();
        send_bits(16'h5A5B, KW, 0);
        send_parity(1'b1);
        repeat (3) tick(); // T+3: in APPLY, key bus updated, one settle cycle left
        check_eq("mid_apply_key", key_out, 16'h5A5B);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        check_eq("async_rst_busy", busy, 1'b0);
        #4 rst_n = 1'b1;
        tick();
        check_model("post_rst");
        check_eq("post_rst_busy", busy, 1'b0);
        run_frame(16'h0F0F, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
- Loads, checks and holds the 16-bit unlock key for the RLL16 locked benchmark netlists (keyIn_0_0..keyIn_0_15).
- Accepts a serial key frame with even parity and latches the key into a shadow register.
- Drives the key bus only after the parity check passes.
- Gates downstream sampling of the locked circuit's outputs until the combinational logic has settled; supports a one-way lock against reload.

Parameters:
- KEY_W, 16, key width; equals the keyIn bus width of the locked netlist.
- SETTLE_CYCLES, 2, cycles from a key_out update to key_applied; legal range 1..15.
- TIMEOUT, 64, idle cycles tolerated inside a frame before abort; legal range 2..255.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_start  in  1  one-cycle pulse that begins a frame.
- key_sdi  in  1  serial key data, LSB first, followed by a parity bit.
- key_sdi_valid  in  1  qualifies key_sdi.
- key_lock  in  1  pulse; freezes the key until the next reset.
- key_out  out  KEY_W  key bus to the locked netlist; bit i drives keyIn_0_i.
- key_applied  out  1  key_out is stable and settled; downstream may sample.
- busy  out  1  frame in progress or settling.
- err  out  1  sticky frame error.
- locked  out  1  lock is in effect.

Behaviour:
- Reset (async assert, sync release): state IDLE. key_out=0, key_applied=0, busy=0, err=0, locked=0; shadow, bit_cnt, idle_cnt and settle_cnt all 0.
- States are IDLE, SHIFT, CHECK, APPLY and ERROR.
- IDLE:
  - key_start with locked=0 → SHIFT; clears shadow, bit_cnt and idle_cnt; key_applied and err are unchanged.
  - key_start with locked=1 is ignored.
- SHIFT:
  - busy=1.
  - Each cycle with key_sdi_valid=1 and bit_cnt<KEY_W: shadow[bit_cnt] <= key_sdi, bit_cnt++, idle_cnt cleared.
  - When bit_cnt==KEY_W, the next valid bit is the parity bit; it is captured and the state moves to CHECK.
  - Each cycle with key_sdi_valid=0 increments idle_cnt; idle_cnt reaching TIMEOUT → ERROR.
  - key_start in SHIFT restarts the frame (shadow and bit_cnt cleared), with no error.
- CHECK (1 cycle):
  - Pass when XOR(shadow, parity)==0 → APPLY.
  - Otherwise → ERROR.
- APPLY:
  - On entry, key_out <= shadow and key_applied <= 0 in the same edge, and settle_cnt is loaded with SETTLE_CYCLES.
  - settle_cnt decrements each cycle.
  - At 0: key_applied <= 1, busy <= 0, → IDLE.
  - key_start is ignored while in APPLY.
- ERROR:
  - err=1, busy=0; key_out and key_applied keep their previous values, since a bad frame never corrupts the held key.
  - key_start (locked=0) clears err and goes to SHIFT.
- key_lock:
  - Accepted only in IDLE with key_applied=1; sets locked=1 until reset.
  - Ignored in any other state or condition.
- Latency: with the parity bit sampled at edge T, CHECK occupies T..T+1, key_out changes at edge T+2, and key_applied rises at edge T+2+SETTLE_CYCLES.
- Simultaneous events:
  - key_start together with key_sdi_valid in IDLE: the data bit is ignored; the first key bit is taken the following cycle.
  - key_start together with the final parity bit in SHIFT: the restart wins.
- Reset mid-frame: everything clears, including key_out, and the circuit returns to its locked, wrong-key behaviour.
- key_sdi_valid outside SHIFT is ignored.

Decomposition:
- Package rll_key_pkg holds:
  - the state enum key_state_e {IDLE, SHIFT, CHECK, APPLY, ERROR};
  - KEY_W_DEFAULT=16;
  - the parity function key_parity(vec).
- One sub-module, rll_key_shifter: serial-to-parallel shift with bit_cnt, frame_done and the parity capture. The FSM, timeout, settle counter and lock logic stay in the top level.

Test Plan:
- Reset, then start; send 0xA5C3 LSB first with parity 0 and continuous valid → key_out=16'hA5C3 at edge T+2, key_applied=1 at T+4, err=0, busy=0.
- Send 0x0001 with parity 0 (bad) while 0xA5C3 is held → err=1, key_out stays 16'hA5C3, key_applied stays 1; a new start clears err.
- Start, send 8 bits, then hold valid low for 64 cycles → ERROR and err=1 at cycle 64 of inactivity; key_out unchanged.
- Start, send 10 bits, start again, then send the full frame 0x1234 with parity 1 → key_out=16'h1234, no err.
- After 0xA5C3 is applied, pulse key_lock → locked=1; a later frame 0xFFFF with parity 0 is ignored, key_out stays 16'hA5C3; rst_n low → key_out=0, locked=0.
- Assert rst_n low asynchronously mid-APPLY (settle_cnt=1) → all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE.
